// File: rtl/nspi_tx_burst.sv
// Multi-lane SPI burst transmitter: CHANNEL_NUMBER words shifted out in parallel on a
// shared spi_clk/spi_cs_n, with valid/ready streaming so back-to-back words run gaplessly.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | cs_n high, waiting for the first word of a burst
// SETUP     | spi_clk at CPOL, current bit stable on spi_mosi
// LEAD      | spi_clk at ~CPOL (sampling half); trailing tick advances
// WAIT_NEXT | word finished, burst not last: cs_n low, waiting for data
// HOLD      | final half-period before cs_n is released
module nspi_tx_burst #(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE       = 8,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int CLK_DIV        = 1,
  parameter bit CPOL           = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPI_SIZE-1:0]       data_in [CHANNEL_NUMBER],
  input  logic                      data_last,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic                      abort,
  output logic                      spi_clk,
  output logic [CHANNEL_NUMBER-1:0] spi_mosi,
  output logic                      spi_cs_n,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int BW = $clog2(SPI_SIZE);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SPI_SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LEAD,
    S_WAIT_NEXT,
    S_HOLD
  } state_t;

  state_t                                  state_q, state_d;
  logic [DW-1:0]                           div_q, div_d;
  logic [BW-1:0]                           bit_q, bit_d;
  logic                                    last_q, last_d;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] sh_q, sh_d;
  logic                                    sclk_q, sclk_d;
  logic [CHANNEL_NUMBER-1:0]               mosi_q, mosi_d;
  logic                                    cs_n_q, cs_n_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;

  logic                                    tick;
  logic                                    accept;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] load_word;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] load_sh;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] next_sh;
  logic [CHANNEL_NUMBER-1:0]               load_mosi;
  logic [CHANNEL_NUMBER-1:0]               next_mosi;

  // Words are stored in transmit order, so the shifter always emits from its MSB.
  function automatic logic [SPI_SIZE-1:0] order_word(input logic [SPI_SIZE-1:0] w);
    logic [SPI_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SPI_SIZE; i++) begin
      r[i] = MSB_FIRST ? w[i] : w[SPI_SIZE-1-i];
    end
    return r;
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    load_word = '0;
    for (int l = 0; l < CHANNEL_NUMBER; l++) begin
      load_word[l] = order_word(data_in[l]);
    end
  end

  always_comb begin
    load_mosi = '0;
    load_sh   = '0;
    next_mosi = '0;
    next_sh   = '0;
    for (int l = 0; l < CHANNEL_NUMBER; l++) begin
      load_mosi[l] = load_word[l][SPI_SIZE-1];
      load_sh[l]   = {load_word[l][SPI_SIZE-2:0], 1'b0};
      next_mosi[l] = sh_q[l][SPI_SIZE-1];
      next_sh[l]   = {sh_q[l][SPI_SIZE-2:0], 1'b0};
    end
  end

  // Ready only on the trailing tick of a word's final bit keeps bursts gapless.
  always_comb begin
    data_ready = 1'b0;
    if (!abort) begin
      case (state_q)
        S_IDLE, S_WAIT_NEXT: data_ready = 1'b1;
        S_LEAD:              data_ready = (bit_q == BIT_LAST) && !last_q && tick;
        default:             data_ready = 1'b0;
      endcase
    end
  end

  assign accept = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    last_d  = last_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      bit_d   = '0;
      sclk_d  = CPOL;
      mosi_d  = '0;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_SETUP;
            sh_d    = load_sh;
            mosi_d  = load_mosi;
            last_d  = data_last;
            bit_d   = '0;
            sclk_d  = CPOL;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_SETUP: begin
          sclk_d = CPOL;
          if (tick) begin
            state_d = S_LEAD;
            sclk_d  = ~CPOL;
          end
        end
        S_LEAD: begin
          if (tick) begin
            sclk_d = CPOL;
            if (bit_q != BIT_LAST) begin
              state_d = S_SETUP;
              bit_d   = bit_q + 1'b1;
              mosi_d  = next_mosi;
              sh_d    = next_sh;
            end else if (accept) begin
              state_d = S_SETUP;
              bit_d   = '0;
              sh_d    = load_sh;
              mosi_d  = load_mosi;
              last_d  = data_last;
            end else if (last_q) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_WAIT_NEXT;
            end
          end
        end
        S_WAIT_NEXT: begin
          sclk_d = CPOL;
          if (accept) begin
            state_d = S_SETUP;
            bit_d   = '0;
            sh_d    = load_sh;
            mosi_d  = load_mosi;
            last_d  = data_last;
          end
        end
        S_HOLD: begin
          sclk_d = CPOL;
          if (tick) begin
            state_d = S_IDLE;
            cs_n_d  = 1'b1;
            mosi_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Every state change restarts the half-period so each phase is exactly CLK_DIV cycles.
  always_comb begin
    div_d = div_q + 1'b1;
    if (tick || state_d != state_q) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      sh_q    <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_nspi_tx_burst.sv
// Bench for nspi_tx_burst: scoreboard of expected leading-edge lane bits and tx_done times,
// plus a second instance with LSB-first, CLK_DIV=3, CPOL=1.
module tb_nspi_tx_burst;
  localparam int N   = 3;
  localparam int S   = 8;
  localparam int D0  = 1;
  localparam bit CP0 = 1'b0;
  localparam int D1  = 3;
  localparam bit CP1 = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [S-1:0] din0 [N];
  logic         last0 = 1'b0, valid0 = 1'b0, abort0 = 1'b0;
  logic         ready0, sclk0, csn0, busy0, done0;
  logic [N-1:0] mosi0;

  logic [S-1:0] din1 [N];
  logic         last1 = 1'b0, valid1 = 1'b0, abort1 = 1'b0;
  logic         ready1, sclk1, csn1, busy1, done1;
  logic [N-1:0] mosi1;

  nspi_tx_burst #(.CHANNEL_NUMBER(N), .SPI_SIZE(S), .MSB_FIRST(1'b1), .CLK_DIV(D0), .CPOL(CP0)) dut0 (
    .clk(clk), .rst(rst), .data_in(din0), .data_last(last0), .data_valid(valid0),
    .data_ready(ready0), .abort(abort0), .spi_clk(sclk0), .spi_mosi(mosi0),
    .spi_cs_n(csn0), .busy(busy0), .tx_done(done0));

  nspi_tx_burst #(.CHANNEL_NUMBER(N), .SPI_SIZE(S), .MSB_FIRST(1'b0), .CLK_DIV(D1), .CPOL(CP1)) dut1 (
    .clk(clk), .rst(rst), .data_in(din1), .data_last(last1), .data_valid(valid1),
    .data_ready(ready1), .abort(abort1), .spi_clk(sclk1), .spi_mosi(mosi1),
    .spi_cs_n(csn1), .busy(busy1), .tx_done(done1));

  typedef struct {
    logic [N-1:0] bits;
    int           t;
  } bexp_t;

  bexp_t bq[$];
  int    dq[$];
  int    total = 0, bad = 0, pcnt = 0;
  int    lead_cnt = 0, done_cnt = 0, hs_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, pcnt);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, pcnt);
  endtask

  // Monitor: outputs are sampled on the falling clk edge, pcnt = posedges so far.
  initial begin
    bexp_t e;
    int    td;
    logic  prev;
    prev = CP0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (valid0 === 1'b1 && ready0 === 1'b1) hs_cnt++;
        while (bq.size() > 0 && bq[0].t < pcnt) begin
          e = bq.pop_front();
          fail_now("lead_edge_missing", pcnt, e.t);
        end
        while (dq.size() > 0 && dq[0] < pcnt) begin
          td = dq.pop_front();
          fail_now("tx_done_missing", pcnt, td);
        end
        if (sclk0 !== prev && sclk0 === ~CP0) begin
          lead_cnt++;
          if (bq.size() == 0) fail_now("unexpected_lead_edge", pcnt, -1);
          else begin
            e = bq.pop_front();
            check("lead_time", pcnt, e.t);
            check("lead_bits", mosi0, e.bits);
            check("lead_cs_n", csn0, 1'b0);
          end
        end
        if (done0 === 1'b1) begin
          done_cnt++;
          if (dq.size() == 0) fail_now("unexpected_tx_done", pcnt, -1);
          else begin
            td = dq.pop_front();
            check("tx_done_time", pcnt, td);
            check("tx_done_cs_n", csn0, 1'b1);
          end
        end
      end
      prev = sclk0;
    end
  end

  // Called at posedge+2; returns at posedge+2 after the word has been accepted.
  task automatic send0(input logic [N*S-1:0] wp, input logic lst);
    int    guard;
    int    a;
    bexp_t e;
    guard = 0;
    for (int l = 0; l < N; l++) din0[l] = wp[l*S +: S];
    last0  = lst;
    valid0 = 1'b1;
    @(negedge clk);
    while (ready0 !== 1'b1 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (ready0 !== 1'b1) fail_now("accept_timeout", guard, 0);
    else begin
      a = pcnt + 1;
      for (int k = 0; k < S; k++) begin
        for (int l = 0; l < N; l++) e.bits[l] = wp[l*S + (S-1-k)];
        e.t = a + D0 * (2*k + 1);
        bq.push_back(e);
      end
      if (lst) dq.push_back(a + D0 * (2*S + 1));
    end
    @(posedge clk);
    #2;
    valid0 = 1'b0;
    for (int l = 0; l < N; l++) din0[l] = S'($urandom);
    last0 = 1'($urandom);
  endtask

  task automatic gap0(input int n, input bit in_burst);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (in_burst) check("burst_cs_low", csn0, 1'b0);
    end
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (!(busy0 === 1'b0 && bq.size() == 0 && dq.size() == 0) && n < 600) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!(busy0 === 1'b0 && bq.size() == 0 && dq.size() == 0)) fail_now("idle_timeout", n, 600);
  endtask

  task automatic abort0_now();
    int    x;
    bexp_t keep[$];
    int    keepd[$];
    abort0 = 1'b1;
    @(negedge clk);
    x = pcnt + 1;
    foreach (bq[i]) if (bq[i].t < x) keep.push_back(bq[i]);
    foreach (dq[i]) if (dq[i] < x) keepd.push_back(dq[i]);
    bq = keep;
    dq = keepd;
    @(posedge clk);
    #2;
    abort0 = 1'b0;
    check("abort_cs_n", csn0, 1'b1);
    check("abort_sclk", sclk0, CP0);
    check("abort_mosi", mosi0, '0);
    check("abort_busy", busy0, 1'b0);
    check("abort_no_done", done0, 1'b0);
  endtask

  task automatic test_dut1();
    logic [S-1:0] w [N];
    logic [N-1:0] expb;
    logic         prev;
    int           a, k, seen;
    check("d1_idle_sclk", sclk1, 1'b1);
    w[0] = 8'h01;
    w[1] = S'($urandom);
    w[2] = S'($urandom);
    for (int l = 0; l < N; l++) din1[l] = w[l];
    last1  = 1'b1;
    valid1 = 1'b1;
    @(negedge clk);
    check("d1_ready", ready1, 1'b1);
    a = pcnt + 1;
    @(posedge clk);
    #2;
    valid1 = 1'b0;
    for (int l = 0; l < N; l++) din1[l] = S'($urandom);
    check("d1_cs_low", csn1, 1'b0);
    check("d1_busy", busy1, 1'b1);
    k    = 0;
    seen = 0;
    prev = sclk1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (sclk1 !== prev && sclk1 === ~CP1) begin
        if (k < S) begin
          for (int l = 0; l < N; l++) expb[l] = w[l][k];
          check("d1_lead_time", pcnt, a + D1 * (2*k + 1));
          check("d1_lead_bits", mosi1, expb);
        end else fail_now("d1_extra_edge", k, S);
        k++;
      end
      if (done1 === 1'b1) begin
        seen++;
        check("d1_done_time", pcnt, a + D1 * (2*S + 1));
        check("d1_done_cs_n", csn1, 1'b1);
      end
      prev = sclk1;
    end
    check("d1_edge_count", k, S);
    check("d1_done_count", seen, 1);
    check("d1_idle_sclk_after", sclk1, 1'b1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", pcnt);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, d0, h0, n;
    logic [N*S-1:0] r;
    for (int l = 0; l < N; l++) begin
      din0[l] = '0;
      din1[l] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    check("rst_sclk", sclk0, CP0);
    check("rst_mosi", mosi0, '0);
    check("rst_cs_n", csn0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_sclk_cpol1", sclk1, CP1);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("idle_ready", ready0, 1'b1);

    // single word, defaults
    d0 = done_cnt;
    send0({8'hFF, 8'h3C, 8'hA5}, 1'b1);
    check("t1_cs_low", csn0, 1'b0);
    check("t1_busy", busy0, 1'b1);
    wait_idle0();
    check("t1_done_count", done_cnt - d0, 1);

    test_dut1();

    // gapless three-word burst
    l0 = lead_cnt; d0 = done_cnt; h0 = hs_cnt;
    for (int w = 0; w < 3; w++) begin
      r = (N*S)'($urandom);
      send0(r, w == 2);
    end
    wait_idle0();
    check("gapless_edges", lead_cnt - l0, 3 * S);
    check("gapless_done", done_cnt - d0, 1);
    check("gapless_handshakes", hs_cnt - h0, 3);

    // data_valid dropped between words
    l0 = lead_cnt;
    r = (N*S)'($urandom);
    send0(r, 1'b0);
    n = 0;
    while (bq.size() > 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    gap0(10, 1'b1);
    check("wait_sclk_idle", sclk0, CP0);
    check("wait_busy", busy0, 1'b1);
    check("wait_ready", ready0, 1'b1);
    r = (N*S)'($urandom);
    send0(r, 1'b1);
    wait_idle0();
    check("wait_edges", lead_cnt - l0, 2 * S);

    // abort at bit 4 of word 1
    d0 = done_cnt;
    r = (N*S)'($urandom);
    send0(r, 1'b0);
    n = 0;
    while (bq.size() > S - 4 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    abort0_now();
    gap0(20, 1'b0);
    check("abort_done_count", done_cnt - d0, 0);
    r = (N*S)'($urandom);
    send0(r, 1'b1);
    wait_idle0();

    // async reset mid-word
    r = (N*S)'($urandom);
    send0(r, 1'b1);
    gap0(5, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_sclk", sclk0, CP0);
    check("arst_mosi", mosi0, '0);
    check("arst_cs_n", csn0, 1'b1);
    check("arst_busy", busy0, 1'b0);
    check("arst_done", done0, 1'b0);
    bq.delete();
    dq.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", ready0, 1'b1);

    // abort while idle is ignored and blocks acceptance
    abort0 = 1'b1;
    valid0 = 1'b1;
    #1;
    check("idle_abort_ready", ready0, 1'b0);
    @(posedge clk);
    #2;
    check("idle_abort_busy", busy0, 1'b0);
    check("idle_abort_cs_n", csn0, 1'b1);
    abort0 = 1'b0;
    valid0 = 1'b0;

    // randomized bursts
    for (int b = 0; b < 20; b++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        r = (N*S)'($urandom);
        send0(r, w == nw - 1);
        if (w != nw - 1) begin
          if ($urandom_range(0, 5) == 0) begin
            gap0($urandom_range(0, 15), 1'b1);
            abort0_now();
            break;
          end
          if ($urandom_range(0, 1) == 1) gap0($urandom_range(1, 25), 1'b1);
        end
      end
      wait_idle0();
      gap0($urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nspi_tx_burst.md
Name: nspi_tx_burst

Overview:
Parametrised successor to the multi-channel SPI transmitter. Shifts CHANNEL_NUMBER parallel SPI_SIZE-bit words out on a shared spi_clk. It uses a programmable clock divider, selectable bit order and clock polarity, and a shared active-low chip select. A valid/ready handshake lets multi-word bursts stream gaplessly under one CS assertion. The block sits between the frame/line buffer readout and the LED-matrix controller SPI pins, and is fully synchronous to clk.

Parameters:
CHANNEL_NUMBER, 3, number of parallel MOSI lanes
SPI_SIZE, 8, bits per word (>=2)
MSB_FIRST, 1, 1 = bit SPI_SIZE-1 sent first, 0 = bit 0 sent first
CLK_DIV, 1, clk cycles per SPI half-period (>=1)
CPOL, 0, idle level of spi_clk (CPHA fixed 0: data changes on trailing edge, sampled on leading edge)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
data_in  input  [SPI_SIZE-1:0] x [CHANNEL_NUMBER-1:0]  one word per lane (unpacked array, index = lane)
data_last  input  1  qualifies data_in: final word of burst
data_valid  input  1  word available
data_ready  output  1  block accepts word this cycle (combinational)
abort  input  1  synchronous burst abort
spi_clk  output  1  SPI clock
spi_mosi  output  CHANNEL_NUMBER  per-lane data
spi_cs_n  output  1  active-low chip select
busy  output  1  state != IDLE
tx_done  output  1  one-cycle pulse at normal burst end

Behaviour:
- Reset: state IDLE, spi_clk=CPOL, spi_mosi=0, spi_cs_n=1, busy=0, tx_done=0, all counters 0. All outputs except data_ready are registered.
- Clocking: tick = (div_cnt==CLK_DIV-1). div_cnt clears on every state entry and on each tick.
- Bit order: transmitted bit k uses data[SPI_SIZE-1-k] if MSB_FIRST, else data[k]. The word is latched into a shift register on the handshake. data_in may change after the handshake.
- Handshake: a word is accepted when data_valid && data_ready on a rising clk edge.
  - data_ready=1 in IDLE and WAIT_NEXT.
  - data_ready=1 in LEAD when bit_cnt==SPI_SIZE-1 && !last_reg && tick.
  - data_ready=0 otherwise, and 0 whenever abort=1.
- States:
  - IDLE: on accept -> SETUP. Latch word and last_reg, spi_cs_n<=0, mosi<=bit 0 of the word, bit_cnt<=0, busy<=1.
  - SETUP: spi_clk=CPOL. On tick -> LEAD with spi_clk<=~CPOL (leading edge).
  - LEAD: on tick, spi_clk<=CPOL.
    - If bit_cnt<SPI_SIZE-1: bit_cnt++, mosi<=next bit, -> SETUP.
    - Else if an accept occurs this cycle: load the new word, bit_cnt<=0, mosi<=its bit 0, -> SETUP. This is gapless: no extra cycles, CS stays low.
    - Else if last_reg: -> HOLD.
    - Else -> WAIT_NEXT.
  - WAIT_NEXT: spi_clk=CPOL, CS low, mosi holds the last bit. Waits indefinitely. On accept, load the word -> SETUP.
  - HOLD: spi_clk=CPOL for one half-period. On tick: spi_cs_n<=1, spi_mosi<=0, tx_done<=1 for one cycle, busy<=0, -> IDLE.
- Timing, single word, accept at edge 0:
  - cs_n low from cycle 1.
  - Leading edges at cycles 1+CLK_DIV*(2k+1), trailing edges at 1+CLK_DIV*(2k+2), for k=0..SPI_SIZE-1.
  - cs_n high and tx_done at cycle 1+CLK_DIV*(2*SPI_SIZE+1).
- abort (any non-IDLE state) wins over every other event. Next cycle: spi_clk=CPOL, spi_mosi=0, spi_cs_n=1, busy=0, -> IDLE, no tx_done. abort in IDLE has no effect.
- Async rst mid-burst: all outputs return to their reset values immediately; no tx_done.
- data_valid is ignored while data_ready=0; no word is lost or duplicated.

Test Plan:
- Defaults, lanes {8'hA5,8'h3C,8'hFF}, data_last=1, accept at cycle 0 -> cs_n low cycles 1..17, spi_clk rising at 2,4..16. On each rising edge the lanes equal the MSB-first bits (A5: 1,0,1,0,0,1,0,1). cs_n high and tx_done=1 at cycle 18 only.
- MSB_FIRST=0, CLK_DIV=3, CPOL=1, word 8'h01 on lane 0 -> idle spi_clk=1. First falling edge at cycle 4, with lane0=1 there and 0 on all later leading edges. cs_n high at cycle 52.
- Burst of 3 words, data_valid held high, last on word 3 -> exactly 24 clock pulses with a constant period (no gap), cs_n low throughout, a single tx_done, data_ready pulses exactly 3 times.
- Burst with data_valid dropped for 10 cycles between words -> spi_clk idles at CPOL in WAIT_NEXT, cs_n stays low, transmission resumes on accept, the total of 16 pulses is correct.
- abort asserted at bit 4 of word 1 -> next cycle cs_n=1, spi_clk=CPOL, mosi=0, busy=0, no tx_done. A following word transmits normally.
- rst pulse mid-word -> outputs at reset values without waiting for a clk edge. After release, IDLE with data_ready=1.
